// File: rtl/rr_slice_pkg.sv
// Shared types for the round-robin time-sliced arbiter slice.
// Holds FSM states, end-of-grant causes and the default quantum.
package rr_slice_pkg;

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        GAP
    } state_t;

    typedef enum logic [1:0] {
        CAUSE_NONE,
        CAUSE_RELEASE,
        CAUSE_EXPIRE
    } cause_t;

    localparam int DEFAULT_QUANTUM = 1;

endpackage

// File: rtl/slice_timer.sv
// Rollover counter timing one grant slice.
// Ports: clk, n_rst (async low), clear, count_enable, rollover_val,
//        count_out (cycles completed in slice), rollover_flag (last cycle).
module slice_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         n_rst,
    input  logic         clear,
    input  logic         count_enable,
    input  logic [W-1:0] rollover_val,
    output logic [W-1:0] count_out,
    output logic         rollover_flag
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Flag marks the cycle in which the count reaches rollover_val;
    // the count wraps to 0 at that point so it never exceeds it.
    assign rollover_flag = count_enable &&
                           ((count_q + W'(1)) == rollover_val);
    assign count_out     = count_q;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (count_enable) begin
            count_d = rollover_flag ? '0 : count_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/rr_slice_arbiter.sv
// Round-robin time-sliced arbiter with a one-cycle gap between grants.
// Ports: clk, n_rst, req/done (per requester), quantum (slice length),
//        grant (one-hot), grant_valid, grant_id, preempt (expiry gap pulse).
module rr_slice_arbiter
    import rr_slice_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int QUANTUM_BITS = 4
) (
    input  logic                       clk,
    input  logic                       n_rst,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ-1:0]         done,
    input  logic [QUANTUM_BITS-1:0]    quantum,
    output logic [NUM_REQ-1:0]         grant,
    output logic                       grant_valid,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       preempt
);

    localparam int IW = $clog2(NUM_REQ);

    state_t                  state_q;
    logic [NUM_REQ-1:0]      grant_q;
    logic [IW-1:0]           id_q;
    logic [IW-1:0]           last_q;
    logic                    preempt_q;
    logic [QUANTUM_BITS-1:0] quant_q;

    logic [IW:0]             pick;
    logic                    any_req;
    logic [IW-1:0]           win_id;
    logic                    others;
    logic                    release_evt;
    logic                    expire;
    logic                    start_grant;
    cause_t                  cause;
    logic [QUANTUM_BITS-1:0] quant_eff;
    logic [QUANTUM_BITS-1:0] slice_cnt;
    logic                    slice_flag;

    // Returns {found, index}. Scanning from the far end keeps the
    // nearest set bit after 'last'; 'last' itself ranks lowest.
    function automatic logic [IW:0] rr_pick(
        input logic [NUM_REQ-1:0] r,
        input logic [IW-1:0]      last
    );
        logic [IW:0] res;
        int          idx;
        res = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = (int'(last) + k) % NUM_REQ;
            if (r[idx]) begin
                res = {1'b1, IW'(idx)};
            end
        end
        return res;
    endfunction

    always_comb begin
        pick        = rr_pick(req, last_q);
        any_req     = pick[IW];
        win_id      = pick[IW-1:0];
        others      = |(req & ~grant_q);
        release_evt = done[id_q] | ~req[id_q];
        // Second term guards against the count ever passing the quantum.
        expire      = (state_q == GRANT) &&
                      (slice_flag || (slice_cnt >= quant_q));
        start_grant = (state_q != GRANT) && any_req;
        quant_eff   = (quantum == '0) ?
                      QUANTUM_BITS'(DEFAULT_QUANTUM) : quantum;
        cause       = CAUSE_NONE;
        if (state_q == GRANT) begin
            if (release_evt) begin
                cause = CAUSE_RELEASE;
            end else if (expire && others) begin
                cause = CAUSE_EXPIRE;
            end
        end
    end

    slice_timer #(
        .W (QUANTUM_BITS)
    ) u_timer (
        .clk           (clk),
        .n_rst         (n_rst),
        .clear         (start_grant),
        .count_enable  (state_q == GRANT),
        .rollover_val  (quant_q),
        .count_out     (slice_cnt),
        .rollover_flag (slice_flag)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            id_q      <= '0;
            last_q    <= IW'(NUM_REQ - 1);
            preempt_q <= 1'b0;
            quant_q   <= QUANTUM_BITS'(DEFAULT_QUANTUM);
        end else begin
            unique case (state_q)
                IDLE, GAP: begin
                    preempt_q <= 1'b0;
                    if (any_req) begin
                        state_q <= GRANT;
                        grant_q <= NUM_REQ'(1) << win_id;
                        id_q    <= win_id;
                        quant_q <= quant_eff;
                    end else begin
                        state_q <= IDLE;
                        grant_q <= '0;
                        id_q    <= '0;
                    end
                end
                GRANT: begin
                    // Renewal needs no action: the timer wraps itself.
                    if (cause != CAUSE_NONE) begin
                        state_q   <= GAP;
                        grant_q   <= '0;
                        id_q      <= '0;
                        last_q    <= id_q;
                        preempt_q <= (cause == CAUSE_EXPIRE);
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    grant_q   <= '0;
                    id_q      <= '0;
                    preempt_q <= 1'b0;
                end
            endcase
        end
    end

    assign grant       = grant_q;
    assign grant_valid = |grant_q;
    assign grant_id    = id_q;
    assign preempt     = preempt_q;

endmodule

// File: tb/tb_rr_slice_arbiter.sv
// Directed scoreboard bench for rr_slice_arbiter.
// Expected grant/preempt per cycle are queued on drive, popped after the edge.
module tb_rr_slice_arbiter;

    logic       clk;
    logic       n_rst;
    logic [3:0] req;
    logic [3:0] done;
    logic [3:0] quantum;
    logic [3:0] grant;
    logic       grant_valid;
    logic [1:0] grant_id;
    logic       preempt;

    int checks;
    int failures;

    typedef struct packed {
        logic       pre;
        logic [3:0] gnt;
    } exp_t;

    exp_t sb[$];

    rr_slice_arbiter #(
        .NUM_REQ      (4),
        .QUANTUM_BITS (4)
    ) dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .req         (req),
        .done        (done),
        .quantum     (quantum),
        .grant       (grant),
        .grant_valid (grant_valid),
        .grant_id    (grant_id),
        .preempt     (preempt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [1:0] oh_idx(input logic [3:0] g);
        logic [1:0] r;
        r = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (g[i]) r = 2'(i);
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input exp_t e);
        chk({tag, ".grant"}, {4'h0, grant}, {4'h0, e.gnt});
        chk({tag, ".valid"}, {7'h0, grant_valid}, {7'h0, |e.gnt});
        chk({tag, ".id"}, {6'h0, grant_id}, {6'h0, oh_idx(e.gnt)});
        chk({tag, ".preempt"}, {7'h0, preempt}, {7'h0, e.pre});
    endtask

    // Drive inputs for one cycle; outputs after the next edge must match.
    task automatic cyc(input string tag, input logic [3:0] r,
                       input logic [3:0] d, input logic [3:0] q,
                       input logic [3:0] eg, input logic ep);
        exp_t e;
        req     = r;
        done    = d;
        quantum = q;
        sb.push_back('{pre: ep, gnt: eg});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk_all(tag, e);
    endtask

    task automatic do_reset();
        @(negedge clk);
        n_rst = 1'b0;
        req   = '0;
        done  = '0;
        @(negedge clk);
        n_rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        n_rst    = 1'b0;
        req      = '0;
        done     = '0;
        quantum  = 4'd3;
        #2;
        chk_all("reset", '{pre: 1'b0, gnt: 4'b0000});
        do_reset();

        // Reset mid-grant, then first grant latency after release.
        cyc("rst_g1", 4'b0001, 4'b0, 4'd3, 4'b0001, 1'b0);
        cyc("rst_g2", 4'b0001, 4'b0, 4'd3, 4'b0001, 1'b0);
        #3;
        n_rst = 1'b0;
        #1;
        chk_all("async_rst", '{pre: 1'b0, gnt: 4'b0000});
        req = 4'b0000;
        @(negedge clk);
        n_rst = 1'b1;
        @(posedge clk);
        #1;
        cyc("rst_idle", 4'b0000, 4'b0, 4'd3, 4'b0000, 1'b0);
        cyc("rst_lat", 4'b0001, 4'b0, 4'd3, 4'b0001, 1'b0);
        cyc("rst_drop", 4'b0000, 4'b0, 4'd3, 4'b0000, 1'b0);
        cyc("rst_idle2", 4'b0000, 4'b0, 4'd3, 4'b0000, 1'b0);

        // Full contention rotation, quantum 3.
        do_reset();
        for (int k = 0; k < 4; k++) begin
            repeat (3) cyc("rot_g", 4'hF, 4'b0, 4'd3, 4'(1 << k), 1'b0);
            cyc("rot_gap", 4'hF, 4'b0, 4'd3, 4'b0000, 1'b1);
        end
        cyc("rot_wrap", 4'hF, 4'b0, 4'd3, 4'b0001, 1'b0);
        cyc("rot_drop", 4'h0, 4'b0, 4'd3, 4'b0000, 1'b0);
        cyc("rot_idle", 4'h0, 4'b0, 4'd3, 4'b0000, 1'b0);

        // Early release by done, then non-owner and idle done ignored.
        do_reset();
        cyc("er_g1", 4'b0011, 4'b0000, 4'd5, 4'b0001, 1'b0);
        cyc("er_g2", 4'b0011, 4'b0000, 4'd5, 4'b0001, 1'b0);
        cyc("er_gap", 4'b0011, 4'b0001, 4'd5, 4'b0000, 1'b0);
        cyc("er_next", 4'b0011, 4'b0000, 4'd5, 4'b0010, 1'b0);
        cyc("er_nonown", 4'b0011, 4'b0001, 4'd5, 4'b0010, 1'b0);
        cyc("er_drop", 4'b0000, 4'b0000, 4'd5, 4'b0000, 1'b0);
        cyc("er_idle", 4'b0000, 4'b1111, 4'd5, 4'b0000, 1'b0);
        cyc("er_idle2", 4'b0000, 4'b0000, 4'd5, 4'b0000, 1'b0);

        // Renewal with a sole requester.
        do_reset();
        repeat (7) cyc("renew", 4'b0100, 4'b0, 4'd2, 4'b0100, 1'b0);
        cyc("renew_gap", 4'b0000, 4'b0, 4'd2, 4'b0000, 1'b0);
        cyc("renew_idle", 4'b0000, 4'b0, 4'd2, 4'b0000, 1'b0);

        // Quantum 0 behaves as 1.
        do_reset();
        cyc("q0_a", 4'b0011, 4'b0, 4'd0, 4'b0001, 1'b0);
        cyc("q0_gap1", 4'b0011, 4'b0, 4'd0, 4'b0000, 1'b1);
        cyc("q0_b", 4'b0011, 4'b0, 4'd0, 4'b0010, 1'b0);
        cyc("q0_gap2", 4'b0011, 4'b0, 4'd0, 4'b0000, 1'b1);
        cyc("q0_c", 4'b0011, 4'b0, 4'd0, 4'b0001, 1'b0);
        cyc("q0_drop", 4'b0000, 4'b0, 4'd0, 4'b0000, 1'b0);

        // Quantum change mid-slice is ignored; next slice latches 7.
        do_reset();
        cyc("qc_g1", 4'b0011, 4'b0, 4'd2, 4'b0001, 1'b0);
        cyc("qc_g2", 4'b0011, 4'b0, 4'd7, 4'b0001, 1'b0);
        cyc("qc_gap", 4'b0011, 4'b0, 4'd7, 4'b0000, 1'b1);
        repeat (7) cyc("qc_q7", 4'b0011, 4'b0, 4'd7, 4'b0010, 1'b0);
        cyc("qc_gap2", 4'b0011, 4'b0, 4'd7, 4'b0000, 1'b1);
        cyc("qc_back", 4'b0011, 4'b0, 4'd7, 4'b0001, 1'b0);
        cyc("qc_drop", 4'b0000, 4'b0, 4'd7, 4'b0000, 1'b0);

        // Done coinciding with expiry: release wins, no preempt.
        do_reset();
        cyc("de_g1", 4'b0011, 4'b0000, 4'd2, 4'b0001, 1'b0);
        cyc("de_g2", 4'b0011, 4'b0000, 4'd2, 4'b0001, 1'b0);
        cyc("de_gap", 4'b0011, 4'b0001, 4'd2, 4'b0000, 1'b0);
        cyc("de_next", 4'b0011, 4'b0000, 4'd2, 4'b0010, 1'b0);
        cyc("de_drop", 4'b0000, 4'b0000, 4'd2, 4'b0000, 1'b0);

        chk("sb_empty", 8'(sb.size()), 8'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rr_slice_arbiter.md
Name: rr_slice_arbiter

Overview:
- Round-robin, time-sliced arbiter that shares one datapath resource between NUM_REQ requesters.
- Each grant lasts until the owner releases it, or until a programmable quantum of cycles expires while another requester is waiting.
- The quantum is timed by an internal rollover counter with clear, enable and a programmable rollover value.
- A registered one-hot grant is produced; a mandatory one-cycle dead gap separates consecutive grants so the resource can turn around.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
QUANTUM_BITS, 4, width of the quantum value and the slice counter

Ports:
clk  input  1  system clock
n_rst  input  1  reset, asynchronous, active-low
req  input  NUM_REQ  level request per requester; held high while it wants the resource
done  input  NUM_REQ  per-requester early-release pulse; honoured only from the current owner
quantum  input  QUANTUM_BITS  maximum granted cycles per slice under contention; 0 treated as 1
grant  output  NUM_REQ  registered one-hot grant; all zero when no owner
grant_valid  output  1  OR of grant
grant_id  output  $clog2(NUM_REQ)  index of the owner; 0 when grant_valid=0
preempt  output  1  one-cycle pulse in the gap cycle that follows a quantum-expiry preemption

Behaviour:
- Reset (async, any state, mid-grant included): state=IDLE; grant=0; grant_valid=0; grant_id=0; preempt=0; last_owner=NUM_REQ-1 (req[0] wins first); slice counter=0; latched quantum=1.
- FSM states: IDLE, GRANT, GAP. All outputs are registered.
- IDLE:
  - If any req is high at an edge, load grant with the round-robin winner and go to GRANT.
  - The grant appears the cycle after req is first sampled high (1-cycle latency).
- Round-robin search starts at (last_owner+1) mod NUM_REQ and takes the first set req bit, wrapping around.
- Entering GRANT:
  - Latch the quantum, with 0 mapped to 1. Changes to the quantum input during a slice are ignored.
  - Clear the slice counter.
- GRANT:
  - The counter increments by 1 each granted cycle.
  - expire is true in the granted cycle where count equals the latched quantum, i.e. the Q-th granted cycle.
- End of grant. At an edge in GRANT, go to GAP with grant=0 if any of the following holds:
  - done[owner]=1, or
  - req[owner]=0, or
  - expire=1 and some other req bit is high.
- Renewal: expire=1 with no other requester keeps the owner granted, clears the counter, and starts a fresh slice with no gap. preempt stays 0.
- Priority of end causes: release (done or req drop) beats expiry. If release and expiry occur in the same cycle, preempt=0.
- done bits from non-owners are ignored. done during IDLE or GAP is ignored.
- GAP:
  - Lasts exactly 1 cycle with grant=0. last_owner is updated to the departing owner.
  - preempt=1 in this cycle only when the end cause was expiry.
  - At the end of GAP, arbitrate again: go to GRANT with the new winner if any req is high, else go to IDLE.
  - The departing owner can win again only if it is the sole requester.
- Invariants:
  - grant is always one-hot or zero.
  - Under continuous contention a slice never exceeds Q cycles.
  - Every requester is granted within (NUM_REQ-1)*(Q+1) cycles of asserting req.
- Counter width: the counter rolls at the latched quantum and never overflows. quantum = 2^QUANTUM_BITS-1 is legal.

Decomposition:
- Package rr_slice_pkg contains:
  - state_t enum {IDLE, GRANT, GAP}
  - end-cause enum {CAUSE_NONE, CAUSE_RELEASE, CAUSE_EXPIRE}
  - localparam for the default quantum of 1
- Sub-module slice_timer: a parameterised rollover counter.
  - Ports: clk, n_rst, clear, count_enable, rollover_val, count_out, rollover_flag.
  - Instantiated once, with rollover_val set to the latched quantum.
- The round-robin priority search is a combinational function in the arbiter.

Test Plan:
- Reset mid-grant: req=0001, quantum=3; assert n_rst low while grant=0001 -> all outputs 0 immediately, without waiting for a clock edge. After release, req[0] is granted 1 cycle after the first sampling edge.
- Contention rotation: req=1111 held, quantum=3 -> grant sequence 0001(3 cycles), gap, 0010(3), gap, 0100(3), gap, 1000(3), gap, 0001; preempt pulses in each gap.
- Early release: req=0011, quantum=5; done[0] pulsed in the 2nd granted cycle -> grant 0001 for 2 cycles, gap with preempt=0, then 0010.
- Renewal: req=0100 only, quantum=2, held 7 cycles -> grant 0100 continuous for 7 cycles with no gap and preempt=0. Then req[2] drops -> gap, then IDLE.
- Quantum edge cases:
  - quantum=0 with req=0011 -> 1-cycle slices alternating 0001/0010 with gaps.
  - Change quantum from 2 to 7 mid-slice -> the current slice still ends after 2 cycles.
- Simultaneous events:
  - done[owner] in the same cycle as expiry with others pending -> preempt=0.
  - done from a non-owner -> no effect on the grant.
  - grant_id always matches the one-hot grant.
